// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake states and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the single-ported RAM between icache and dcache: dcache-first priority,
// locked dcache block transfers, and a bounded-starvation escape for icache.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        dlock,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          merr_q, merr_d;

  ramstate_t     rs;
  logic          ireq, dreq, done, take_arb, arb_bump;
  arb_state_e    arb_pick;

  assign rs   = ramstate_t'(ramstate);
  assign ireq = iREN;
  assign dreq = dREN | dWEN;
  assign done = (state_q != IDLE) && (rs == ACCESS);

  // Single arbitration decision shared by the IDLE path and every completion.
  always_comb begin
    arb_pick = IDLE;
    arb_bump = 1'b0;
    if (ireq && (starve_q == STARVE_LIM)) begin
      arb_pick = GNT_I;
    end else if (dreq) begin
      arb_pick = GNT_D;
      arb_bump = ireq;
    end else if (ireq) begin
      arb_pick = GNT_I;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    take_arb = 1'b0;
    merr_d   = merr_q | ((state_q != IDLE) && (rs == ERROR));
    case (state_q)
      IDLE:  take_arb = 1'b1;
      GNT_I: begin
        if (done)       take_arb = 1'b1;
        else if (!iREN) state_d  = IDLE;
      end
      GNT_D: begin
        // A locked completion keeps the grant and does not count as a decision.
        if (done) begin
          if (!dlock) take_arb = 1'b1;
        end else if (!dREN && !dWEN && !dlock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_arb) begin
      state_d = arb_pick;
      if (arb_pick == GNT_I) begin
        starve_d = '0;
      end else if (arb_bump && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      merr_q   <= merr_d;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = (rs != ACCESS);
      end
      GNT_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = (rs != ACCESS);
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign merr  = merr_q;

endmodule
